prio_dec_pulse: RTL and testbench

//   Receive side of the 4-line priority-encode path. Takes an encoded index
//   {valid, index} from the priority encoder and re-expands it to one-hot.

---
 rtl/prio_dec_pulse.sv | 134 +++++++++++++
 tb/tb_prio_dec_pulse.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prio_dec_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : prio_dec_pulse
//  Purpose  : Receive side of the priority-encode path. Accepts an encoded
//             {valid, index}, re-expands it to a one-hot line held high for
//             PULSE_LEN cycles, then enforces GAP extra low cycles before the
//             next accept. Flags out-of-range indices and counts good decodes.
//  Revision : 1.0  initial release
// ============================================================================
module prio_dec_pulse #(
    parameter int N         = 4,
    parameter int IDX_W     = 2,
    parameter int PULSE_LEN = 1,
    parameter int GAP       = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             in_ready,
    output logic [N-1:0]     out_onehot,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] evt_cnt
);

    // The timer reloads with PULSE_LEN-1 or GAP-1, so it only needs to hold
    // values up to max(PULSE_LEN, GAP) - 1.
    localparam int MAXC = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]    C_PULSE_INIT = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]    C_GAP_INIT   = TW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [IDX_W:0]   C_N_LIM      = (IDX_W + 1)'(N);
    localparam logic [N-1:0]     C_ONE        = N'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    logic w_xfer;
    logic w_in_range;

    // Ready only while idle; reset masks it so nothing is taken during reset.
    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign w_xfer     = in_valid && in_ready;
    // Zero-extend the index so N == 2**IDX_W compares correctly.
    assign w_in_range = ({1'b0, in_idx} < C_N_LIM);

    assign out_onehot = onehot_q;
    assign err        = err_q;
    assign busy       = busy_q;
    assign evt_cnt    = evt_q;

    // Next-state and output decode for the accept / drive / gap sequence.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        onehot_d = onehot_q;
        evt_d    = evt_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_xfer) begin
                    if (w_in_range) begin
                        onehot_d = C_ONE << in_idx;
                        tmr_d    = C_PULSE_INIT;
                        evt_d    = (evt_q == C_CNT_MAX) ? evt_q : evt_q + CNT_W'(1);
                        state_d  = S_DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRIVE: begin
                if (tmr_q == '0) begin
                    onehot_d = '0;
                    if (GAP > 0) begin
                        tmr_d   = C_GAP_INIT;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                onehot_d = '0;
                state_d  = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            onehot_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            evt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            onehot_q <= onehot_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            evt_q    <= evt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prio_dec_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_dec_pulse
//  Purpose  : Randomized bench for prio_dec_pulse. Three instances with
//             different parameter sets are driven independently and compared
//             every cycle against a time-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prio_dec_pulse;

    localparam int NCYC = 3000;
    localparam int ND   = 3;

    // Per-instance parameters: default set; N=3 with long pulse, gap and a
    // 2-bit counter; long pulse with short gap.
    localparam int P_N  [ND] = '{4, 3, 4};
    localparam int P_PL [ND] = '{1, 3, 4};
    localparam int P_GAP[ND] = '{0, 2, 1};
    localparam int P_CW [ND] = '{8, 2, 8};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld [ND];
    logic [1:0] idx [ND];
    logic       rdy [ND];
    logic       bsy [ND];
    logic       er  [ND];

    logic [3:0] oh_a, oh_c;
    logic [2:0] oh_b;
    logic [7:0] cnt_a, cnt_c;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: everything expressed as absolute cycle numbers.
    int m_line     [ND];
    int m_hi_until [ND];
    int m_ready_at [ND];
    int m_err_at   [ND];
    int m_cnt      [ND];
    bit pending    [ND];

    always #5 clk = ~clk;

    prio_dec_pulse #(.N(4), .IDX_W(2), .PULSE_LEN(1), .GAP(0), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_idx(idx[0]),
        .in_ready(rdy[0]), .out_onehot(oh_a), .busy(bsy[0]), .err(er[0]),
        .evt_cnt(cnt_a)
    );

    prio_dec_pulse #(.N(3), .IDX_W(2), .PULSE_LEN(3), .GAP(2), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_idx(idx[1]),
        .in_ready(rdy[1]), .out_onehot(oh_b), .busy(bsy[1]), .err(er[1]),
        .evt_cnt(cnt_b)
    );

    prio_dec_pulse #(.N(4), .IDX_W(2), .PULSE_LEN(4), .GAP(1), .CNT_W(8)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_idx(idx[2]),
        .in_ready(rdy[2]), .out_onehot(oh_c), .busy(bsy[2]), .err(er[2]),
        .evt_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_dut(input int d, input int c, input logic [31:0] oh,
                               input logic [31:0] cnt);
        logic [31:0] e_oh;
        string       t;
        e_oh = (c <= m_hi_until[d]) ? (32'd1 << m_line[d]) : 32'd0;
        t    = $sformatf("d%0d c%0d", d, c);
        check({t, " onehot"},   oh, e_oh);
        check({t, " onecount"}, 32'($countones(oh) <= 1), 32'd1);
        check({t, " in_ready"}, 32'(rdy[d]), 32'((c >= m_ready_at[d]) && !rst));
        check({t, " busy"},     32'(bsy[d]), 32'(c < m_ready_at[d]));
        check({t, " err"},      32'(er[d]),  32'(c == m_err_at[d]));
        check({t, " evt_cnt"},  cnt, 32'(m_cnt[d]));
    endtask

    initial begin
        int rst_left;
        rst_left = 0;
        for (int d = 0; d < ND; d++) begin
            vld[d]        = 1'b0;
            idx[d]        = 2'd0;
            m_line[d]     = 0;
            m_hi_until[d] = -1;
            m_ready_at[d] = 0;
            m_err_at[d]   = -1;
            m_cnt[d]      = 0;
            pending[d]    = 1'b0;
        end

        for (int c = 0; c < NCYC; c++) begin
            if (c > 0) @(negedge clk);

            // Reset: 3 cycles at start, a forced 3-cycle burst at 300 and
            // occasional random 3-cycle bursts.
            if (c < 3) begin
                rst = 1'b1;
            end else if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else if (c == 300 || $urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                rst_left = 2;
            end else begin
                rst = 1'b0;
            end

            // A refused request is usually held with its index unchanged.
            for (int d = 0; d < ND; d++) begin
                if (!(pending[d] && $urandom_range(0, 7) != 0)) begin
                    vld[d] = 1'($urandom_range(0, 1));
                    idx[d] = 2'($urandom_range(0, 3));
                end
            end

            #1;
            if (c > 0) begin
                compare_dut(0, c, 32'(oh_a), 32'(cnt_a));
                compare_dut(1, c, 32'(oh_b), 32'(cnt_b));
                compare_dut(2, c, 32'(oh_c), 32'(cnt_c));
            end

            // Advance the model across the coming edge.
            for (int d = 0; d < ND; d++) begin
                pending[d] = 1'b0;
                if (rst) begin
                    m_hi_until[d] = -1;
                    m_ready_at[d] = c + 1;
                    m_err_at[d]   = -1;
                    m_cnt[d]      = 0;
                end else if (vld[d] && c >= m_ready_at[d]) begin
                    if (int'(idx[d]) < P_N[d]) begin
                        m_line[d]     = int'(idx[d]);
                        m_hi_until[d] = c + P_PL[d];
                        m_ready_at[d] = c + P_PL[d] + P_GAP[d] + 1;
                        if (m_cnt[d] < (1 << P_CW[d]) - 1) m_cnt[d]++;
                    end else begin
                        m_err_at[d] = c + 1;
                    end
                end else if (vld[d]) begin
                    pending[d] = 1'b1;
                end
            end

            @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
